// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 scan-code receiver.
//   PS2_FRAME_BITS : bits per PS/2 frame (start, 8 data, parity, stop)
//   PS2_BREAK_CODE : key-release prefix byte
//   ps2_entry_t    : one received-code FIFO entry {brk, code}
//   ps2_frame_ok() : frame check on a complete frame, bit 0 = start bit
package ps2_pkg;

   localparam int unsigned PS2_FRAME_BITS = 11;
   localparam logic [7:0]  PS2_BREAK_CODE = 8'hF0;

   typedef struct packed {
      logic       brk;
      logic [7:0] code;
   } ps2_entry_t;

   // Start low, stop high, and odd parity over the data byte plus parity bit.
   function automatic logic ps2_frame_ok(input logic [PS2_FRAME_BITS-1:0] f);
      return !f[0] && f[10] && (^f[9:1]);
   endfunction

endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo -- synchronous FIFO of received scan-code entries.
//   clk, rst      : system clock, asynchronous active-high reset
//   wr_en/wr_data : push request; accepted when not full, or when a pop
//                   happens in the same cycle
//   rd_en         : pop the head entry (ignored when empty)
//   rd_data       : head entry, all zeros while empty
//   empty, full   : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ps2_fifo
   import ps2_pkg::*;
#(
   parameter int  DEPTH = 8,
   parameter type T     = ps2_entry_t
) (
   input  logic clk,
   input  logic rst,
   input  logic wr_en,
   input  T     wr_data,
   input  logic rd_en,
   output T     rd_data,
   output logic empty,
   output logic full
);

   localparam int AW = $clog2(DEPTH);

   T             mem [DEPTH];
   logic [AW:0]  wptr;
   logic [AW:0]  rptr;
   logic         do_wr;
   logic         do_rd;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

   // When full, a simultaneous pop frees the head slot, which is exactly the
   // slot being written; the old head is still read out this cycle.
   assign do_wr = wr_en && (!full || rd_en);
   assign do_rd = rd_en && !empty;

   assign rd_data = empty ? T'('0) : mem[rptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (do_wr) wptr <= wptr + 1'b1;
         if (do_rd) rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx -- PS/2 keyboard receiver with a scan-code FIFO.
//   clk, rst            : system clock, asynchronous active-high reset
//   ps2_clk, ps2_data   : raw keyboard lines, asynchronous to clk
//   out_code/out_brk    : head entry of the FIFO
//   out_valid/out_ready : FIFO non-empty / consumer pops the head
//   err_frame           : one-cycle pulse on a rejected frame
//   overflow            : sticky, a good byte was dropped on a full FIFO
// Build option: define PS2_BREAK_FILTER_EN to fold the 0xF0 release prefix
// into the brk flag of the following byte; otherwise every byte is queued
// and out_brk stays 0.
module ps2_scan_rx
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] out_code,
   output logic       out_brk,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       err_frame,
   output logic       overflow
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [2:0]    sync_clk;
   logic [1:0]    sync_data;
   logic          fall;
   logic          sd;
   logic [3:0]    bitcnt;
   logic [9:0]    shreg;
   logic [TW-1:0] tcnt;
   logic          last;
   logic          ok;
   logic [7:0]    rx_byte;
   logic          push_req;
   ps2_entry_t    push_entry;
   ps2_entry_t    head;
   logic          empty;
   logic          full;
   logic          pop;

   assign fall    = (sync_clk[2:1] == 2'b10);
   assign sd      = sync_data[1];
   assign last    = fall && (bitcnt == 4'(PS2_FRAME_BITS - 1));
   assign ok      = ps2_frame_ok({sd, shreg});
   assign rx_byte = shreg[8:1];
   assign pop     = out_valid && out_ready;

`ifdef PS2_BREAK_FILTER_EN
   logic brk_pend;

   always_comb begin
      push_req   = last && ok && (rx_byte != PS2_BREAK_CODE);
      push_entry = '{brk: brk_pend, code: rx_byte};
   end

   // Repeated 0xF0 keeps the flag set; any other good byte consumes it and a
   // rejected frame cancels it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         brk_pend <= 1'b0;
      end else if (last) begin
         brk_pend <= ok && (rx_byte == PS2_BREAK_CODE);
      end
   end
`else
   always_comb begin
      push_req   = last && ok;
      push_entry = '{brk: 1'b0, code: rx_byte};
   end
`endif

   // Synchronisers, bit counter and inactivity timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_clk  <= '1;
         sync_data <= '1;
         bitcnt    <= '0;
         shreg     <= '0;
         tcnt      <= '0;
         err_frame <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         sync_clk  <= {sync_clk[1:0], ps2_clk};
         sync_data <= {sync_data[0], ps2_data};
         err_frame <= last && !ok;

         if (push_req && full && !pop) overflow <= 1'b1;

         if (fall) begin
            shreg <= {sd, shreg[9:1]};
            if (last) bitcnt <= '0;
            else      bitcnt <= bitcnt + 1'b1;
         end

         if (bitcnt == '0 || fall) begin
            tcnt <= '0;
         end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            tcnt   <= '0;
            bitcnt <= '0;
         end else begin
            tcnt <= tcnt + 1'b1;
         end
      end
   end

   ps2_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (ps2_entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push_req),
      .wr_data (push_entry),
      .rd_en   (pop),
      .rd_data (head),
      .empty   (empty),
      .full    (full)
   );

   assign out_valid = !empty;
   assign out_code  = head.code;
   assign out_brk   = head.brk;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx -- directed bench for ps2_scan_rx (small TIMEOUT_CYC).
module tb_ps2_scan_rx;

   localparam int TMO = 200;
   localparam int H   = 8;   // PS/2 half-period in clk cycles

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] out_code;
   logic       out_brk;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       err_frame;
   logic       overflow;

   int vectors = 0;
   int miscompares = 0;
   int err_cnt = 0;

   ps2_scan_rx #(
      .FIFO_DEPTH  (8),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .out_code  (out_code),
      .out_brk   (out_brk),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err_frame (err_frame),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (err_frame) err_cnt++;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One PS/2 bit; with lat set, checks out_valid around the falling edge.
   task automatic send_bit(input logic b, input bit lat);
      tick(1);
      ps2_data = b;
      tick(H);
      ps2_clk = 1'b0;
      if (lat) begin
         tick(2);
         chk("valid_before", out_valid, 0);
         tick(1);
         chk("valid_latency", out_valid, 1);
         tick(H - 3);
      end else begin
         tick(H);
      end
      ps2_clk = 1'b1;
   endtask

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) send_bit(f[i], 1'b0);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit lat);
      logic [10:0] f;
      f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(f[i], lat && (i == 10));
      tick(H);
   endtask

   task automatic pop_check(input string tag, input logic [7:0] c, input logic b);
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_code"}, out_code, c);
      chk({tag, "_brk"}, out_brk, b);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
   endtask

   initial begin
      int e0;
      logic [7:0] held;
      tick(3);
      chk("rst_valid", out_valid, 0);
      chk("rst_code", out_code, 0);
      chk("rst_brk", out_brk, 0);
      chk("rst_err", err_frame, 0);
      chk("rst_ovf", overflow, 0);
      rst = 1'b0;
      tick(4);

      // Single good frame, latency checked on the stop bit.
      send_frame(8'h1C, 1'b0, 1'b1);
      pop_check("f1C", 8'h1C, 1'b0);
      chk("f1C_empty", out_valid, 0);

      // Break prefix.
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
`ifdef PS2_BREAK_FILTER_EN
      pop_check("brk1C", 8'h1C, 1'b1);
`else
      pop_check("rawF0", 8'hF0, 1'b0);
      pop_check("raw1C", 8'h1C, 1'b0);
`endif
      chk("brk_empty", out_valid, 0);

      // Bad parity, then recovery.
      e0 = err_cnt;
      send_frame(8'h1C, 1'b1, 1'b0);
      chk("par_err_pulses", err_cnt - e0, 1);
      chk("par_no_entry", out_valid, 0);
      send_frame(8'h21, 1'b0, 1'b0);
      pop_check("after_err", 8'h21, 1'b0);
      chk("par_ovf", overflow, 0);

      // Overflow at depth 8.
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
      chk("ovf_flag", overflow, 1);
      held = out_code;
      tick(5);
      chk("hold_code", out_code, 8'h01);
      chk("hold_same", out_code, held);
      for (int i = 1; i <= 8; i++) pop_check("ovf_rd", 8'(i), 1'b0);
      chk("ovf_empty", out_valid, 0);
      chk("ovf_sticky", overflow, 1);

      // Partial frame abandoned by timeout.
      e0 = err_cnt;
      send_bits(11'b00000101010, 4);
      tick(TMO + 10);
      send_frame(8'h21, 1'b0, 1'b0);
      pop_check("tmo21", 8'h21, 1'b0);
      chk("tmo_empty", out_valid, 0);
      chk("tmo_no_err", err_cnt - e0, 0);

      // Reset mid-frame with entries queued.
      send_frame(8'h11, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0);
      send_frame(8'h33, 1'b0, 1'b0);
      chk("q3_valid", out_valid, 1);
      send_bits({1'b1, 1'b0, 8'h5A, 1'b0}, 7);
      #2 rst = 1'b1;
      #1;
      chk("mrst_valid", out_valid, 0);
      chk("mrst_code", out_code, 0);
      chk("mrst_brk", out_brk, 0);
      chk("mrst_err", err_frame, 0);
      chk("mrst_ovf", overflow, 0);
      tick(2);
      rst = 1'b0;
      tick(4);
      chk("post_rst_empty", out_valid, 0);
      send_frame(8'h44, 1'b0, 1'b0);
      pop_check("post_rst", 8'h44, 1'b0);
      chk("post_rst_end", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
